// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with per-operation ack/error status and a debug FSM.
// A simultaneous read+write on a partly filled FIFO is serviced as one pass-through cycle.
module fifo_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_LEVEL   = 2**ADDR_WIDTH - 1,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [2:0]            state
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = CW'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_C    = CW'(AE_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        INIT   = 3'b000,
        WRITE  = 3'b001,
        WR_ERR = 3'b010,
        NO_OP  = 3'b011,
        READ   = 3'b100,
        RD_ERR = 3'b101,
        RDWR   = 3'b110
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic do_wr;
    logic do_rd;
    logic illegal;

    assign state        = state_q;
    assign full         = (data_count == DEPTH_C);
    assign empty        = (data_count == '0);
    assign almost_full  = (data_count >= AF_C);
    assign almost_empty = (data_count <= AE_C);
    assign illegal      = (3'(state_q) == 3'b111);

    // Acceptance depends only on the request and the pre-edge occupancy.
    assign do_wr = wr_en && !full  && !illegal;
    assign do_rd = rd_en && !empty && !illegal;

    // Storage is not reset; only the control path is.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            dout       <= '0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
            rd_ack     <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            wr_ack <= do_wr;
            rd_ack <= do_rd;
            wr_err <= wr_en && !do_wr && !illegal;
            rd_err <= rd_en && !do_rd && !illegal;

            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_wr && !do_rd) begin
                data_count <= data_count + CNT_ONE;
            end else if (do_rd && !do_wr) begin
                data_count <= data_count - CNT_ONE;
            end

            if (illegal) begin
                state_q <= INIT;
            end else if (do_wr && do_rd) begin
                state_q <= RDWR;
            end else if (do_wr) begin
                state_q <= WRITE;
            end else if (do_rd) begin
                state_q <= READ;
            end else if (wr_en) begin
                state_q <= WR_ERR;
            end else if (rd_en) begin
                state_q <= RD_ERR;
            end else begin
                state_q <= NO_OP;
            end
        end
    end

endmodule
